// File: rtl/temperature_pkg.sv
// Shared types and constants for the sequential temperature monitor.
package temperature_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DIV   = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Default acceptable window and clear margin
  localparam int unsigned TEMP_LOW_DEF  = 19;
  localparam int unsigned TEMP_HIGH_DEF = 26;
  localparam int unsigned HYST_DEF      = 1;

  // Accumulator width large enough that summing nr readings never overflows
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned nr);
    return data_w + $clog2(nr + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// Result is valid W cycles after start_i; done_o pulses alongside the final bit.
// A zero divisor yields an all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [W:0]       w_shift;
  logic [W:0]       w_sub;
  logic             w_ge;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    w_shift = {r_rem, r_quo[W-1]};
    w_ge    = (w_shift >= {1'b0, r_div});
    w_sub   = w_shift - {1'b0, r_div};
  end

  // Iteration registers: dividend bits shift out of r_quo as quotient bits shift in
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (start_i) begin
      r_quo  <= dividend_i;
      r_rem  <= '0;
      r_div  <= divisor_i;
      r_cnt  <= CNT_W'(W);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_quo  <= W'({r_quo, w_ge});
      r_rem  <= w_ge ? W'(w_sub) : W'(w_shift);
      r_cnt  <= r_cnt - CNT_W'(1);
      r_done <= (r_cnt == CNT_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done_o      = r_done;
  assign quotient_o  = r_quo;
  assign remainder_o = r_rem;

endmodule

// File: rtl/temperature_monitor_seq.sv
// Sequential temperature monitor: snapshot, serial accumulate, serial divide,
// round, and hysteresis-filtered alert, with a start/busy/valid handshake.
module temperature_monitor_seq
  import temperature_pkg::*;
#(
  parameter int unsigned NR_OF_SENSORS = 5,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned TEMP_LOW      = TEMP_LOW_DEF,
  parameter int unsigned TEMP_HIGH     = TEMP_HIGH_DEF,
  parameter int unsigned HYST          = HYST_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [NR_OF_SENSORS*DATA_W-1:0] sensors_data_i,
  input  logic [NR_OF_SENSORS-1:0]        sensors_en_i,
  output logic                            busy_o,
  output logic                            valid_o,
  output logic [DATA_W-1:0]               avg_o,
  output logic [7:0]                      nr_active_o,
  output logic                            no_sensor_o,
  output logic                            alert_o
);

  localparam int unsigned SUM_W   = sum_width(DATA_W, NR_OF_SENSORS);
  localparam int unsigned CYC_MAX = (NR_OF_SENSORS > SUM_W) ? NR_OF_SENSORS : SUM_W;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned CLR_LO  = TEMP_LOW + HYST;
  localparam int unsigned CLR_HI  = TEMP_HIGH - HYST;

  state_e r_state;
  state_e w_state_nxt;

  logic [NR_OF_SENSORS*DATA_W-1:0] r_data;
  logic [NR_OF_SENSORS-1:0]        r_en;
  logic [SUM_W-1:0]                r_sum;
  logic [7:0]                      r_count;
  logic [CYC_W-1:0]                r_cyc;
  logic [DATA_W-1:0]               r_avg_rnd;

  logic                            r_busy;
  logic                            r_valid;
  logic [DATA_W-1:0]               r_avg;
  logic [7:0]                      r_nr_active;
  logic                            r_no_sensor;
  logic                            r_alert;

  logic                            w_acc_last;
  logic                            w_div_last;
  logic [SUM_W-1:0]                w_sum_nxt;
  logic [7:0]                      w_cnt_nxt;

  logic                            w_snap_c;
  logic                            w_acc_c;
  logic                            w_div_start_c;
  logic                            w_cyc_clr_c;
  logic                            w_cyc_inc_c;
  logic                            w_round_c;
  logic                            w_done_c;

  logic                            w_div_done;
  logic [SUM_W-1:0]                w_quo;
  logic [SUM_W-1:0]                w_rem;
  logic [SUM_W:0]                  w_rem2;
  logic                            w_round_up;
  logic [SUM_W:0]                  w_q_rnd;
  logic [DATA_W-1:0]               w_avg_rnd;
  logic                            w_alert_nxt;

  // Phase-end detection for the shared cycle counter
  assign w_acc_last = (r_cyc == CYC_W'(NR_OF_SENSORS - 1));
  assign w_div_last = (r_cyc == CYC_W'(SUM_W - 1));

  // Channel 0 of the shifting snapshot is always the one being added
  assign w_sum_nxt = r_sum + (r_en[0] ? SUM_W'(r_data[DATA_W-1:0]) : SUM_W'(0));
  assign w_cnt_nxt = r_count + 8'(r_en[0]);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_i)    w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_acc_last) w_state_nxt = ST_DIV;
      ST_DIV:   if (w_div_last) w_state_nxt = ST_ROUND;
      ST_ROUND:                 w_state_nxt = ST_DONE;
      ST_DONE:                  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    w_snap_c      = 1'b0;
    w_acc_c       = 1'b0;
    w_div_start_c = 1'b0;
    w_cyc_clr_c   = 1'b0;
    w_cyc_inc_c   = 1'b0;
    w_round_c     = 1'b0;
    w_done_c      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_snap_c    = start_i;
        w_cyc_clr_c = start_i;
      end
      ST_ACCUM: begin
        w_acc_c       = 1'b1;
        w_div_start_c = w_acc_last;
        w_cyc_clr_c   = w_acc_last;
        w_cyc_inc_c   = !w_acc_last;
      end
      ST_DIV:   w_cyc_inc_c = 1'b1;
      ST_ROUND: w_round_c   = 1'b1;
      ST_DONE:  w_done_c    = 1'b1;
      default:  ;
    endcase
  end

  // Snapshot, serial accumulation and phase cycle counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_en    <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_cyc   <= '0;
    end else begin
      if (w_snap_c) begin
        r_data  <= sensors_data_i;
        r_en    <= sensors_en_i;
        r_sum   <= '0;
        r_count <= '0;
      end else if (w_acc_c) begin
        r_data  <= r_data >> DATA_W;
        r_en    <= r_en >> 1;
        r_sum   <= w_sum_nxt;
        r_count <= w_cnt_nxt;
      end
      if (w_cyc_clr_c) begin
        r_cyc <= '0;
      end else if (w_cyc_inc_c) begin
        r_cyc <= r_cyc + CYC_W'(1);
      end
    end
  end

  // Divider is launched with the final sum and count, in parallel with the last add
  seq_divider #(
    .W (SUM_W)
  ) u_div (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (w_div_start_c),
    .dividend_i  (w_sum_nxt),
    .divisor_i   (SUM_W'(w_cnt_nxt)),
    .done_o      (w_div_done),
    .quotient_o  (w_quo),
    .remainder_o (w_rem)
  );

  // Round half up, saturate; a zero count or unfinished divide forces zero
  assign w_rem2     = {w_rem, 1'b0};
  assign w_round_up = (w_rem2 >= (SUM_W+1)'(r_count));
  assign w_q_rnd    = {1'b0, w_quo} + (SUM_W+1)'(w_round_up);

  always_comb begin
    w_avg_rnd = '0;
    if ((r_count != 8'd0) && w_div_done) begin
      if (|w_q_rnd[SUM_W:DATA_W]) begin
        w_avg_rnd = '1;
      end else begin
        w_avg_rnd = w_q_rnd[DATA_W-1:0];
      end
    end
  end

  // Rounded average captured in ROUND
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_avg_rnd <= '0;
    end else if (w_round_c) begin
      r_avg_rnd <= w_avg_rnd;
    end
  end

  // Hysteresis alert: set outside the window, clear only inside the inner band
  always_comb begin
    w_alert_nxt = r_alert;
    if (r_count == 8'd0) begin
      w_alert_nxt = 1'b1;
    end else if ((32'(r_avg_rnd) < TEMP_LOW) || (32'(r_avg_rnd) > TEMP_HIGH)) begin
      w_alert_nxt = 1'b1;
    end else if ((32'(r_avg_rnd) >= CLR_LO) && (32'(r_avg_rnd) <= CLR_HI)) begin
      w_alert_nxt = 1'b0;
    end
  end

  // Result and handshake registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_avg       <= '0;
      r_nr_active <= '0;
      r_no_sensor <= 1'b0;
      r_alert     <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_valid <= w_done_c;
      if (w_done_c) begin
        r_avg       <= r_avg_rnd;
        r_nr_active <= r_count;
        r_no_sensor <= (r_count == 8'd0);
        r_alert     <= w_alert_nxt;
      end
    end
  end

  assign busy_o      = r_busy;
  assign valid_o     = r_valid;
  assign avg_o       = r_avg;
  assign nr_active_o = r_nr_active;
  assign no_sensor_o = r_no_sensor;
  assign alert_o     = r_alert;

endmodule

// File: tb/tb_temperature_monitor_seq.sv
// Scoreboard bench for temperature_monitor_seq at default parameters.
module tb_temperature_monitor_seq;

  localparam int N      = 5;
  localparam int DW     = 8;
  localparam int SUM_W  = 11;
  localparam int LAT    = N + SUM_W + 2;
  localparam int PERIOD = N + SUM_W + 3;
  localparam int T_LOW  = 19;
  localparam int T_HIGH = 26;
  localparam int HYS    = 1;

  typedef struct {
    int     avg;
    int     nr;
    int     nos;
    int     alert;
    longint start_edge;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [N*DW-1:0]   sensors_data;
  logic [N-1:0]      sensors_en;
  logic              busy_o;
  logic              valid_o;
  logic [DW-1:0]     avg_o;
  logic [7:0]        nr_active_o;
  logic              no_sensor_o;
  logic              alert_o;

  exp_t   sb[$];
  int     checks   = 0;
  int     failures = 0;
  longint edge_cnt = 0;
  int     m_alert  = 0;

  temperature_monitor_seq dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .sensors_data_i (sensors_data),
    .sensors_en_i   (sensors_en),
    .busy_o         (busy_o),
    .valid_o        (valid_o),
    .avg_o          (avg_o),
    .nr_active_o    (nr_active_o),
    .no_sensor_o    (no_sensor_o),
    .alert_o        (alert_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: rounded mean of enabled readings plus the alert rules
  function automatic void model(input logic [N*DW-1:0] d, input logic [N-1:0] en,
                                output exp_t e);
    int sum = 0;
    int cnt = 0;
    int avg;
    for (int k = 0; k < N; k++) begin
      if (en[k]) begin
        sum += int'(d[k*DW +: DW]);
        cnt++;
      end
    end
    if (cnt == 0) avg = 0;
    else avg = (2 * sum + cnt) / (2 * cnt);
    if (avg > 255) avg = 255;
    if (cnt == 0) m_alert = 1;
    else if (avg < T_LOW || avg > T_HIGH) m_alert = 1;
    else if (avg >= T_LOW + HYS && avg <= T_HIGH - HYS) m_alert = 0;
    e.avg   = avg;
    e.nr    = cnt;
    e.nos   = (cnt == 0) ? 1 : 0;
    e.alert = m_alert;
    e.start_edge = 0;
  endfunction

  // Monitor: each valid_o pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency_edge", edge_cnt, e.start_edge + LAT);
        chk("avg_o", avg_o, e.avg);
        chk("nr_active_o", nr_active_o, e.nr);
        chk("no_sensor_o", no_sensor_o, e.nos);
        chk("alert_o", alert_o, e.alert);
      end
    end
  end

  task automatic wait_idle();
    int i = 0;
    while (busy_o !== 1'b0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (busy_o !== 1'b0) chk("idle_timeout", 1, 0);
  endtask

  // Issue one request from a negedge; scramble inputs right after the sampling edge
  task automatic measure(input logic [N*DW-1:0] d, input logic [N-1:0] en, input bit push);
    exp_t e;
    wait_idle();
    sensors_data = d;
    sensors_en   = en;
    start        = 1'b1;
    if (push) begin
      model(d, en, e);
      e.start_edge = edge_cnt + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    sensors_data = (N*DW)'({$urandom(), $urandom()});
    sensors_en   = N'($urandom());
  endtask

  function automatic logic [N*DW-1:0] one_ch(input int v);
    logic [N*DW-1:0] d = '0;
    d[DW-1:0] = DW'(v);
    return d;
  endfunction

  initial begin
    int hyst_vals[7] = '{30, 26, 25, 19, 18, 19, 20};
    logic [N*DW-1:0] d;
    logic [N-1:0]    en;
    exp_t            e;
    longint          s0;
    int              i;

    rst_n = 1'b0;
    start = 1'b0;
    sensors_data = '0;
    sensors_en   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_avg", avg_o, 0);
    chk("rst_nr", nr_active_o, 0);
    chk("rst_alert", alert_o, 0);

    // Basic average, then the two rounding cases
    measure({8'd0, 8'd0, 8'd24, 8'd22, 8'd20}, 5'b00111, 1'b1);
    measure({8'd0, 8'd0, 8'd0, 8'd21, 8'd20}, 5'b00011, 1'b1);
    measure({8'd0, 8'd0, 8'd21, 8'd20, 8'd20}, 5'b00111, 1'b1);

    // Hysteresis walk
    foreach (hyst_vals[k]) measure(one_ch(hyst_vals[k]), 5'b00001, 1'b1);

    // No sensors enabled
    measure({8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 5'b00000, 1'b1);

    // Extra starts during ACCUM and DIV are dropped
    measure({8'd33, 8'd0, 8'd27, 8'd0, 8'd23}, 5'b10101, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held high: one result per PERIOD
    wait_idle();
    d  = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    en = 5'b11111;
    sensors_data = d;
    sensors_en   = en;
    start = 1'b1;
    s0 = edge_cnt + 1;
    for (int k = 0; k < 3; k++) begin
      model(d, en, e);
      e.start_edge = s0 + longint'(k * PERIOD);
      sb.push_back(e);
    end
    repeat (2 * PERIOD + 1) @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of DIV discards the measurement
    measure({8'd0, 8'd0, 8'd0, 8'd0, 8'd40}, 5'b00001, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_avg", avg_o, 0);
    chk("mid_rst_nr", nr_active_o, 0);
    chk("mid_rst_alert", alert_o, 0);
    chk("mid_rst_nos", no_sensor_o, 0);
    m_alert = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure({8'd0, 8'd0, 8'd0, 8'd30, 8'd10}, 5'b00011, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) d[c*DW +: DW] = DW'($urandom_range(0, 255));
        else d[c*DW +: DW] = DW'($urandom_range(14, 32));
      end
      en = N'($urandom_range(0, 31));
      measure(d, en, 1'b1);
    end

    // Drain the scoreboard, then watch for stray results
    i = 0;
    while (sb.size() != 0 && i < 4 * PERIOD) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2 * PERIOD) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
